// File: rtl/dmem_responder_pkg.sv
// mips_pkg: shared MIPS-32 constants and the data-memory responder state type
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store request and response bus
interface dmem_responder_if;
    import mips_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    modport master (output req_valid, req_write, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port DEPTHx32 RAM with the read result registered at the commit edge
module dmem_array
    import mips_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic                     clr,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clock)
        if (we) mem[addr] <= wdata;
    // rdata keeps its value between responses; stores and rejected accesses report 0
    always_ff @(posedge clock)
        if (reset || clr) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory responder (optional DMEM_ALIGN_CHECK_EN flags misaligned words)
module dmem_responder
    import mips_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave s
);
    localparam int AW = $clog2(DEPTH);
    dmem_state_t       state, state_n;
    logic [3:0]        cnt;
    logic              wr_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              idle, accept, commit, ready, valid;
    logic              cur_wr, cur_mis;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic              unused_addr;
    assign idle   = state == IDLE;
    assign accept = idle && s.req_valid;
    always_comb begin
        state_n = state;
        ready   = 1'b0;
        valid   = 1'b0;
        if (state == IDLE) begin
            ready   = 1'b1;
            state_n = s.req_valid ? (LATENCY > 1 ? WAIT : RESP) : IDLE;
        end else if (state == WAIT) begin
            state_n = cnt == 4'd1 ? RESP : WAIT;
        end else begin
            valid   = 1'b1;
            state_n = IDLE;
        end
    end
    always_ff @(posedge clock)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= accept ? 4'(LATENCY - 1) : (state == WAIT ? cnt - 4'd1 : cnt);
        end
    always_ff @(posedge clock)
        if (accept) begin
            wr_q    <= s.req_write;
            idx_q   <= s.req_addr[AW+1:2];
            wdata_q <= s.req_wdata;
        end
    // with LATENCY=1 the commit edge is the accept edge, so use the live request
    assign cur_wr    = idle ? s.req_write : wr_q;
    assign cur_idx   = idle ? s.req_addr[AW+1:2] : idx_q;
    assign cur_wdata = idle ? s.req_wdata : wdata_q;
    assign commit    = !reset && state != RESP && state_n == RESP;
`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q, err_q;
    always_ff @(posedge clock)
        if (accept) mis_q <= |s.req_addr[1:0];
    assign cur_mis = idle ? |s.req_addr[1:0] : mis_q;
    always_ff @(posedge clock)
        if (reset) err_q <= 1'b0;
        else if (commit) err_q <= cur_mis;
    assign s.resp_err = err_q;
`else
    assign cur_mis    = 1'b0;
    assign s.resp_err = 1'b0;
`endif
    assign unused_addr = ^{s.req_addr[WORD_W-1:AW+2], s.req_addr[1:0]};
    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clock (clock),
        .reset (reset),
        .we    (commit && cur_wr && !cur_mis),
        .re    (commit && !cur_wr && !cur_mis),
        .clr   (commit && (cur_wr || cur_mis)),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (s.resp_rdata)
    );
    assign s.req_ready  = ready;
    assign s.resp_valid = valid;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder for the MIPS-32 pipeline. It is the memory end of the MEM-stage load/store interface: it accepts one word request per handshake, holds it for a configurable wait time, then commits the store or returns the load data with a one-cycle response strobe. The MEM-stage initiator stalls on `req_ready` low. This replaces the zero-latency data memory so stall/hazard logic can be exercised.

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two, 4..65536.
- `LATENCY`, 2: cycles from accept edge to `resp_valid`; legal range 1..15.
- `clock` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder idle and able to accept.
- `req_write` in 1: 1 = store (sw), 0 = load (lw).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: single-cycle completion strobe, for both loads and stores.
- `resp_rdata` out 32: load data, valid while `resp_valid`=1.
- `resp_err` out 1: misaligned-access flag, valid while `resp_valid`=1.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. Accept on `req_valid && req_ready` at an edge.
  - Capture `req_write`, `req_addr`, `req_wdata`.
  - Load the wait counter with LATENCY-1.
  - Next state is WAIT if LATENCY>1, else RESP.
- WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 1 at an edge, go to RESP.
- Commit edge: the edge that enters RESP.
  - Store: `mem[idx]` ← captured wdata.
  - Load: `resp_rdata` ← `mem[idx]`.
- RESP: `resp_valid`=1 and `req_ready`=0 for exactly one cycle, then IDLE.
  - `resp_rdata`=0 for stores.
  - `resp_rdata` holds its last value outside RESP. The bench checks it only under `resp_valid`.
- Index: `idx = req_addr[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo DEPTH*4.
- Request inputs are ignored while `req_ready`=0. No queuing. The initiator must hold `req_valid` until it is accepted.
- Memory contents are not cleared by reset. Simulation initialises them to 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter 0.
- Latency: accept at edge N gives `resp_valid` high in cycle N+LATENCY, i.e. after edge N+LATENCY-1 and until edge N+LATENCY.
- Throughput: one request per LATENCY+1 cycles. `req_ready` returns high the cycle after RESP.
- Reset during WAIT: the request is abandoned and an uncommitted store does not reach memory.
- Reset asserted in the same cycle as a commit edge: reset wins and no store is performed.
- Reset during RESP: `resp_valid` drops at that edge.
- Load after store to the same address: always returns the new data, because the store commits before `req_ready` reasserts.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - On a request with `req_addr[1:0]`≠0, the commit edge performs no array access.
  - The response has `resp_rdata`=0 and `resp_err`=1.
  - Timing is unchanged.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `req_addr[1:0]` is ignored.
  - `resp_err` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - the state typedef `dmem_state_t` (IDLE/WAIT/RESP);
  - the word width constant `WORD_W`=32;
  - the opcode constants `OP_LW`=6'b100011 and `OP_SW`=6'b101011, which the MEM-stage initiator uses to drive `req_write`.
- One sub-module, `dmem_array`: synchronous single-port RAM with write enable, DEPTH×32, with the read registered at the commit edge.
- The FSM, counter and request capture registers live in `dmem_responder`.

## Test plan
- Reset: hold `reset` for 2 cycles. Expect `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Store then load, LATENCY=2:
  - sw addr 0x10, data 0xDEADBEEF accepted at edge N. Expect `resp_valid` in cycle N+2 only.
  - lw 0x10 accepted at edge N+3. Expect `resp_rdata`=0xDEADBEEF in cycle N+5.
- LATENCY=1 back-to-back with `req_valid` held high: responses arrive every 2 cycles, and `req_ready` alternates 1/0.
- Wrap, DEPTH=256: sw 0x400 data 0x12345678, then lw 0x000. Expect 0x12345678.
- Reset mid-operation:
  - sw 0x20 data 0xA5A5A5A5 with LATENCY=4, reset asserted in cycle 2 of WAIT. Expect no `resp_valid`.
  - Then lw 0x20. Expect the prior contents (0).
- Alignment check:
  - With `DMEM_ALIGN_CHECK_EN`: lw 0x13 gives `resp_err`=1 and `resp_rdata`=0; sw 0x11 leaves word 4 unchanged.
  - Without the macro: lw 0x13 returns word 4 and `resp_err`=0.
